// File: rtl/acc_array.sv
// acc_array: bank of N_COL independent column accumulators. Each column sums
// ifmap_ch partial sums per output pixel, adds a per-column bias, shifts right
// arithmetically, optionally applies ReLU, saturates to OUT_W bits and presents
// the result with its pixel address and a last flag on a valid/ready port.
module acc_array #(
  parameter int N_COL  = 16,
  parameter int PSUM_W = 16,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 8,
  parameter int ADDR_W = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [4:0]                ofmap_size_i,
  input  logic [5:0]                ifmap_ch_i,
  input  logic [4:0]                shift_i,
  input  logic                      relu_en_i,
  input  logic [N_COL*PSUM_W-1:0]   bias_i,
  input  logic [N_COL*PSUM_W-1:0]   psum_i,
  input  logic [N_COL-1:0]          pvalid_i,
  output logic [N_COL-1:0]          pready_o,
  output logic [N_COL-1:0]          conv_valid_o,
  input  logic [N_COL-1:0]          conv_ready_i,
  output logic [N_COL-1:0]          conv_last_o,
  output logic [N_COL*OUT_W-1:0]    conv_result_o,
  output logic [N_COL*ADDR_W-1:0]   addr_o,
  output logic                      busy_o,
  output logic                      done_o
);

  if (ACC_W < PSUM_W + 6) begin : g_acc_w_check
    $error("acc_array: ACC_W must be at least PSUM_W+6");
  end
  if (ADDR_W < 10) begin : g_addr_w_check
    $error("acc_array: ADDR_W must hold 31*31-1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} col_state_t;

  logic                     start_ok;
  logic [9:0]               pix_total;
  logic [4:0]               shift_q;
  logic                     relu_q;
  logic [5:0]               ch_q;
  logic [ADDR_W-1:0]        last_pix_q;
  logic [N_COL*PSUM_W-1:0]  bias_q;
  logic [N_COL-1:0]         col_busy;
  logic [N_COL-1:0]         col_done;

  // A start with a zero channel count or zero map size is ignored entirely.
  assign start_ok  = start_i && (ifmap_ch_i != '0) && (ofmap_size_i != '0);
  assign pix_total = {5'd0, ofmap_size_i} * {5'd0, ofmap_size_i};

  // Shared configuration, latched on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      relu_q     <= 1'b0;
      ch_q       <= '0;
      last_pix_q <= '0;
      bias_q     <= '0;
    end else if (start_ok) begin
      shift_q    <= shift_i;
      relu_q     <= relu_en_i;
      ch_q       <= ifmap_ch_i;
      last_pix_q <= ADDR_W'(pix_total - 10'd1);
      bias_q     <= bias_i;
    end
  end

  for (genvar c = 0; c < N_COL; c++) begin : g_col
    col_state_t                state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   psum_x;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W:0]     biased;
    logic signed [ACC_W:0]     shifted;
    logic signed [ACC_W:0]     clamped;
    logic [ACC_W-OUT_W+1:0]    upper;
    logic [OUT_W-1:0]          sat;
    logic [PSUM_W-1:0]         psum;
    logic [PSUM_W-1:0]         bias;
    logic [5:0]                ch_cnt_q;
    logic [ADDR_W-1:0]         pix_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [OUT_W-1:0]          result_q;
    logic                      valid_q;
    logic                      last_q;
    logic                      ready;
    logic                      accept;
    logic                      handshake;
    logic                      ch_last;
    logic                      pix_last;

    assign psum      = psum_i[c*PSUM_W +: PSUM_W];
    assign bias      = bias_q[c*PSUM_W +: PSUM_W];
    assign ready     = (state_q == RUN) && (!valid_q || conv_ready_i[c]);
    assign accept    = pvalid_i[c] && ready;
    assign handshake = valid_q && conv_ready_i[c];
    assign ch_last   = (ch_cnt_q == ch_q - 6'd1);
    assign pix_last  = (pix_q == last_pix_q);

    // Accumulate, bias, shift, ReLU and saturate the running sum.
    always_comb begin
      psum_x  = {{(ACC_W-PSUM_W){psum[PSUM_W-1]}}, psum};
      sum     = (ch_cnt_q == '0) ? psum_x : acc_q + psum_x;
      biased  = {sum[ACC_W-1], sum} + {{(ACC_W+1-PSUM_W){bias[PSUM_W-1]}}, bias};
      shifted = biased >>> shift_q;
      clamped = (relu_q && shifted[ACC_W]) ? '0 : shifted;
      upper   = clamped[ACC_W:OUT_W-1];
      if (upper == '0 || upper == '1) begin
        sat = clamped[OUT_W-1:0];
      end else if (clamped[ACC_W]) begin
        sat = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        sat = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end

    // Column state register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
      end else begin
        state_q <= state_d;
      end
    end

    // Column next-state: start overrides everything, otherwise run/drain/done.
    always_comb begin
      state_d = state_q;
      if (start_ok) begin
        state_d = RUN;
      end else begin
        unique case (state_q)
          IDLE:    state_d = IDLE;
          RUN:     if (accept && ch_last && pix_last) state_d = DRAIN;
          DRAIN:   if (handshake) state_d = DONE;
          DONE:    state_d = DONE;
          default: state_d = IDLE;
        endcase
      end
    end

    // Accumulator, counters and output register; start wins over handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q    <= '0;
        ch_cnt_q <= '0;
        pix_q    <= '0;
        addr_q   <= '0;
        result_q <= '0;
        valid_q  <= 1'b0;
        last_q   <= 1'b0;
      end else if (start_ok) begin
        acc_q    <= '0;
        ch_cnt_q <= '0;
        pix_q    <= '0;
        addr_q   <= '0;
        result_q <= '0;
        valid_q  <= 1'b0;
        last_q   <= 1'b0;
      end else begin
        if (handshake) begin
          valid_q <= 1'b0;
        end
        if (accept) begin
          if (ch_last) begin
            ch_cnt_q <= '0;
            result_q <= sat;
            addr_q   <= pix_q;
            last_q   <= pix_last;
            valid_q  <= 1'b1;
            if (!pix_last) begin
              pix_q <= pix_q + 1'b1;
            end
          end else begin
            ch_cnt_q <= ch_cnt_q + 6'd1;
            acc_q    <= sum;
          end
        end
      end
    end

    assign pready_o[c]                      = ready;
    assign conv_valid_o[c]                  = valid_q;
    assign conv_last_o[c]                   = last_q;
    assign conv_result_o[c*OUT_W +: OUT_W]  = result_q;
    assign addr_o[c*ADDR_W +: ADDR_W]       = addr_q;
    assign col_busy[c]                      = (state_q == RUN) || (state_q == DRAIN);
    assign col_done[c]                      = (state_q == DONE);
  end

  assign busy_o = |col_busy;
  assign done_o = &col_done;

endmodule

// File: tb/tb_acc_array.sv
// Directed bench for acc_array: one task per scenario, expected values by hand.
module tb_acc_array;
  localparam int N_COL  = 16;
  localparam int PSUM_W = 16;
  localparam int OUT_W  = 8;
  localparam int ADDR_W = 10;

  logic                     clk;
  logic                     rst_n;
  logic                     start_i;
  logic [4:0]               ofmap_size_i;
  logic [5:0]               ifmap_ch_i;
  logic [4:0]               shift_i;
  logic                     relu_en_i;
  logic [N_COL*PSUM_W-1:0]  bias_i;
  logic [N_COL*PSUM_W-1:0]  psum_i;
  logic [N_COL-1:0]         pvalid_i;
  logic [N_COL-1:0]         pready_o;
  logic [N_COL-1:0]         conv_valid_o;
  logic [N_COL-1:0]         conv_ready_i;
  logic [N_COL-1:0]         conv_last_o;
  logic [N_COL*OUT_W-1:0]   conv_result_o;
  logic [N_COL*ADDR_W-1:0]  addr_o;
  logic                     busy_o;
  logic                     done_o;

  acc_array #(.N_COL(N_COL), .PSUM_W(PSUM_W), .ACC_W(24), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .ofmap_size_i(ofmap_size_i),
    .ifmap_ch_i(ifmap_ch_i), .shift_i(shift_i), .relu_en_i(relu_en_i), .bias_i(bias_i),
    .psum_i(psum_i), .pvalid_i(pvalid_i), .pready_o(pready_o), .conv_valid_o(conv_valid_o),
    .conv_ready_i(conv_ready_i), .conv_last_o(conv_last_o), .conv_result_o(conv_result_o),
    .addr_o(addr_o), .busy_o(busy_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  int stim[$];
  int r0_val[$], r0_addr[$], r0_last[$], r0_done[$], r0_cyc[$];
  int r3_val[$], r3_addr[$];
  int s3_pready[$], s3_valid[$], s3_val[$];
  bit tmo;

  task automatic pulse_start(input int size, input int ch, input int sh, input int relu, input int b);
    @(negedge clk);
    ofmap_size_i = 5'(size);
    ifmap_ch_i   = 6'(ch);
    shift_i      = 5'(sh);
    relu_en_i    = 1'(relu);
    bias_i       = {N_COL{PSUM_W'(b)}};
    start_i      = 1'b1;
    @(negedge clk);
    start_i      = 1'b0;
    pvalid_i     = '0;
  endtask

  // Feeds stim to every column independently, holding column 3's result ready
  // low for the first hold3 cycles, and records what comes out.
  task automatic stream(input int hold3);
    int idx [N_COL];
    int cyc;
    bit fin;
    bit all_fed;
    r0_val.delete(); r0_addr.delete(); r0_last.delete(); r0_done.delete(); r0_cyc.delete();
    r3_val.delete(); r3_addr.delete();
    s3_pready.delete(); s3_valid.delete(); s3_val.delete();
    foreach (idx[c]) idx[c] = 0;
    cyc = 0; tmo = 1'b0; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      for (int c = 0; c < N_COL; c++) begin
        if (idx[c] < stim.size()) begin
          psum_i[c*PSUM_W +: PSUM_W] = PSUM_W'(stim[idx[c]]);
          pvalid_i[c] = 1'b1;
        end else begin
          pvalid_i[c] = 1'b0;
        end
      end
      conv_ready_i    = '1;
      conv_ready_i[3] = (cyc >= hold3);
      #1;
      s3_pready.push_back(int'(pready_o[3]));
      s3_valid.push_back(int'(conv_valid_o[3]));
      s3_val.push_back(int'($signed(conv_result_o[3*OUT_W +: OUT_W])));
      if (conv_valid_o[0]) begin
        r0_val.push_back(int'($signed(conv_result_o[OUT_W-1:0])));
        r0_addr.push_back(int'(addr_o[ADDR_W-1:0]));
        r0_last.push_back(int'(conv_last_o[0]));
        r0_done.push_back(int'(done_o));
        r0_cyc.push_back(cyc);
      end
      if (conv_valid_o[3] && conv_ready_i[3]) begin
        r3_val.push_back(int'($signed(conv_result_o[3*OUT_W +: OUT_W])));
        r3_addr.push_back(int'(addr_o[3*ADDR_W +: ADDR_W]));
      end
      all_fed = 1'b1;
      for (int c = 0; c < N_COL; c++) if (idx[c] < stim.size()) all_fed = 1'b0;
      if (all_fed && conv_valid_o == '0) fin = 1'b1;
      for (int c = 0; c < N_COL; c++) if (pvalid_i[c] && pready_o[c]) idx[c]++;
      cyc++;
      if (cyc >= 200) begin
        tmo = 1'b1;
        fin = 1'b1;
      end
    end
    pvalid_i = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; ofmap_size_i = '0; ifmap_ch_i = '0; shift_i = '0;
    relu_en_i = 1'b0; bias_i = '0; psum_i = '0; pvalid_i = '0; conv_ready_i = '0;
    repeat (3) @(negedge clk);
    total++; if (pready_o !== '0) begin bad++; $display("FAIL reset_pready: got %h want 0", pready_o); end
    total++; if (conv_valid_o !== '0) begin bad++; $display("FAIL reset_valid: got %h want 0", conv_valid_o); end
    total++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL reset_done_busy: got %b%b want 00", done_o, busy_o); end
    total++; if (conv_result_o !== '0 || addr_o !== '0 || conv_last_o !== '0) begin bad++; $display("FAIL reset_data: nonzero output data"); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    pulse_start(2, 3, 0, 0, 0);
    total++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin bad++; $display("FAIL basic_busy: got busy=%b done=%b want 1 0", busy_o, done_o); end
    stim = '{10, 20, 30, 10, 20, 30, 10, 20, 30, 10, 20, 30};
    stream(0);
    total++; if (tmo) begin bad++; $display("FAIL basic_timeout: got timeout want completion"); end
    total++; if (r0_val.size() != 4) begin bad++; $display("FAIL basic_count: got %0d want 4", r0_val.size()); end
    if (r0_val.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        total++; if (r0_val[i] != 60) begin bad++; $display("FAIL basic_val[%0d]: got %0d want 60", i, r0_val[i]); end
        total++; if (r0_addr[i] != i) begin bad++; $display("FAIL basic_addr[%0d]: got %0d want %0d", i, r0_addr[i], i); end
        total++; if (r0_last[i] != (i == 3 ? 1 : 0)) begin bad++; $display("FAIL basic_last[%0d]: got %0d want %0d", i, r0_last[i], (i == 3 ? 1 : 0)); end
      end
      total++; if (r0_cyc[0] != 3 || r0_cyc[3] != 12) begin bad++; $display("FAIL basic_timing: got %0d,%0d want 3,12", r0_cyc[0], r0_cyc[3]); end
      total++; if (r0_done[3] != 0) begin bad++; $display("FAIL basic_done_early: got %0d want 0", r0_done[3]); end
    end
    total++; if (r3_val.size() != 4 || r3_val[0] != 60) begin bad++; $display("FAIL basic_col3: got n=%0d want 4 results of 60", r3_val.size()); end
    total++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL basic_done: got done=%b busy=%b want 1 0", done_o, busy_o); end
  endtask

  task automatic test_requant();
    pulse_start(1, 2, 2, 0, 0);
    stim = '{100, 100};
    stream(0);
    total++; if (r0_val.size() != 1 || r0_val[0] != 50) begin bad++; $display("FAIL requant_shift2: got n=%0d v=%0d want 50", r0_val.size(), r0_val[0]); end
    pulse_start(1, 2, 0, 0, 0);
    stim = '{100, 100};
    stream(0);
    total++; if (r0_val.size() != 1 || r0_val[0] != 127) begin bad++; $display("FAIL requant_satpos: got n=%0d v=%0d want 127", r0_val.size(), r0_val[0]); end
    pulse_start(1, 2, 0, 0, 0);
    stim = '{-300, -300};
    stream(0);
    total++; if (r0_val.size() != 1 || r0_val[0] != -128) begin bad++; $display("FAIL requant_satneg: got n=%0d v=%0d want -128", r0_val.size(), r0_val[0]); end
    pulse_start(1, 1, 1, 0, 0);
    stim = '{-7};
    stream(0);
    total++; if (r0_val.size() != 1 || r0_val[0] != -4) begin bad++; $display("FAIL requant_floor: got n=%0d v=%0d want -4", r0_val.size(), r0_val[0]); end
  endtask

  task automatic test_relu_bias();
    pulse_start(1, 1, 0, 0, 10);
    stim = '{-40};
    stream(0);
    total++; if (r0_val.size() != 1 || r0_val[0] != -30) begin bad++; $display("FAIL bias_norelu: got n=%0d v=%0d want -30", r0_val.size(), r0_val[0]); end
    total++; if (r0_size_ok(1) && (r0_addr[0] != 0 || r0_last[0] != 1)) begin bad++; $display("FAIL single_addr_last: got addr=%0d last=%0d want 0 1", r0_addr[0], r0_last[0]); end
    pulse_start(1, 1, 0, 1, 10);
    stim = '{-40};
    stream(0);
    total++; if (r0_val.size() != 1 || r0_val[0] != 0) begin bad++; $display("FAIL bias_relu: got n=%0d v=%0d want 0", r0_val.size(), r0_val[0]); end
  endtask

  function automatic bit r0_size_ok(input int n);
    return r0_val.size() == n;
  endfunction

  task automatic test_backpressure();
    pulse_start(2, 1, 0, 0, 0);
    stim = '{5, 6, 7, 8};
    stream(5);
    total++; if (tmo) begin bad++; $display("FAIL bp_timeout: got timeout want completion"); end
    total++; if (s3_pready.size() < 6 || s3_pready[0] != 1) begin bad++; $display("FAIL bp_first_ready: got %0d want 1", s3_pready[0]); end
    if (s3_pready.size() >= 6) begin
      for (int i = 1; i < 5; i++) begin
        total++; if (s3_pready[i] != 0 || s3_valid[i] != 1 || s3_val[i] != 5) begin
          bad++; $display("FAIL bp_hold[%0d]: got pready=%0d valid=%0d val=%0d want 0 1 5", i, s3_pready[i], s3_valid[i], s3_val[i]);
        end
      end
    end
    total++; if (r3_val.size() != 4) begin bad++; $display("FAIL bp_col3_count: got %0d want 4", r3_val.size()); end
    if (r3_val.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        total++; if (r3_val[i] != 5 + i || r3_addr[i] != i) begin
          bad++; $display("FAIL bp_col3[%0d]: got v=%0d a=%0d want v=%0d a=%0d", i, r3_val[i], r3_addr[i], 5 + i, i);
        end
      end
    end
    total++; if (r0_val.size() != 4 || r0_cyc[3] != 4 || r0_val[3] != 8) begin bad++; $display("FAIL bp_col0: got n=%0d want 4 results ending 8 at cycle 4", r0_val.size()); end
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL bp_done: got %b want 1", done_o); end
  endtask

  task automatic test_restart();
    pulse_start(3, 1, 0, 0, 0);
    stim = '{1, 2};
    stream(0);
    total++; if (r0_val.size() != 2 || busy_o !== 1'b1) begin bad++; $display("FAIL restart_pre: got n=%0d busy=%b want 2 1", r0_val.size(), busy_o); end
    @(negedge clk);
    psum_i = {N_COL{PSUM_W'(3)}}; pvalid_i = '1; conv_ready_i = '0;
    @(negedge clk);
    psum_i = {N_COL{PSUM_W'(99)}};
    total++; if (conv_valid_o[0] !== 1'b1 || addr_o[ADDR_W-1:0] !== ADDR_W'(2)) begin bad++; $display("FAIL restart_pending: got valid=%b addr=%0d want 1 2", conv_valid_o[0], addr_o[ADDR_W-1:0]); end
    ofmap_size_i = 5'd1; ifmap_ch_i = 6'd1; shift_i = '0; relu_en_i = 1'b0; bias_i = '0;
    conv_ready_i = '1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; pvalid_i = '0;
    total++; if (conv_valid_o !== '0 || addr_o !== '0 || conv_result_o !== '0) begin bad++; $display("FAIL restart_clear: got valid=%h want 0", conv_valid_o); end
    total++; if (busy_o !== 1'b1 || pready_o !== '1) begin bad++; $display("FAIL restart_run: got busy=%b pready=%h want 1 all-ones", busy_o, pready_o); end
    stim = '{42};
    stream(0);
    total++; if (r0_val.size() != 1 || r0_val[0] != 42 || r0_addr[0] != 0 || r0_last[0] != 1) begin
      bad++; $display("FAIL restart_result: got n=%0d v=%0d want one result 42 addr 0 last", r0_val.size(), r0_val[0]);
    end
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL restart_done: got %b want 1", done_o); end
  endtask

  task automatic test_midreset();
    pulse_start(2, 1, 0, 0, 0);
    @(negedge clk);
    psum_i = {N_COL{PSUM_W'(9)}}; pvalid_i = '1; conv_ready_i = '0;
    @(negedge clk);
    pvalid_i = '0;
    total++; if (conv_valid_o !== '1) begin bad++; $display("FAIL midreset_pending: got %h want all-ones", conv_valid_o); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (conv_valid_o !== '0 || pready_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0 || conv_result_o !== '0) begin
      bad++; $display("FAIL midreset_clear: got valid=%h busy=%b want 0 0", conv_valid_o, busy_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    conv_ready_i = '1;
  endtask

  task automatic test_zero_cfg();
    pulse_start(2, 0, 0, 0, 0);
    total++; if (busy_o !== 1'b0 || pready_o !== '0 || done_o !== 1'b0) begin bad++; $display("FAIL zero_ch: got busy=%b done=%b want 0 0", busy_o, done_o); end
    pulse_start(0, 3, 0, 0, 0);
    total++; if (busy_o !== 1'b0 || pready_o !== '0 || done_o !== 1'b0) begin bad++; $display("FAIL zero_size: got busy=%b done=%b want 0 0", busy_o, done_o); end
    pulse_start(1, 1, 0, 0, 0);
    stim = '{-5};
    stream(0);
    total++; if (r0_val.size() != 1 || r0_val[0] != -5 || r0_last[0] != 1) begin bad++; $display("FAIL zero_recover: got n=%0d v=%0d want -5", r0_val.size(), r0_val[0]); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_requant();
    test_relu_bias();
    test_backpressure();
    test_restart();
    test_midreset();
    test_zero_cfg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_array.md
# acc_array

Parametrised per-column accumulator bank between the systolic array and the activation stage. Each of N_COL columns sums `ifmap_ch` partial sums per output pixel. It then applies bias, arithmetic right-shift, optional ReLU and saturation. Each result is emitted with a pixel address and a last flag over a valid/ready handshake. Compared with the fixed 16-column accumulator, it adds generic widths, bias and requantisation, ReLU, downstream backpressure, and a start/done control handshake.

## Interface
- N_COL, 16: number of columns.
- PSUM_W, 16: signed psum width.
- ACC_W, 24: accumulator width; elaboration error if ACC_W < PSUM_W+6.
- OUT_W, 8: signed result width.
- ADDR_W, 10: pixel address width; must hold 31*31-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  pulse; latches config, clears all columns.
- ofmap_size_i  in  5  output map side; pixels per column = size².
- ifmap_ch_i  in  6  psums accumulated per pixel.
- shift_i  in  5  arithmetic right-shift amount.
- relu_en_i  in  1  clamp negatives to 0.
- bias_i  in  N_COL*PSUM_W  signed per-column bias; latched at start.
- psum_i  in  N_COL*PSUM_W  signed partial sums.
- pvalid_i  in  N_COL  psum valid.
- pready_o  out  N_COL  psum ready.
- conv_valid_o  out  N_COL  result valid.
- conv_ready_i  in  N_COL  result ready.
- conv_last_o  out  N_COL  final pixel of the map.
- conv_result_o  out  N_COL*OUT_W  signed result.
- addr_o  out  N_COL*ADDR_W  pixel index of the result.
- busy_o  out  1  any column not IDLE/DONE.
- done_o  out  1  all columns DONE; level, held until the next start.

## Operation
- Per-column FSM: IDLE → RUN → DRAIN → DONE.
  - start_i moves every column to RUN, unless ifmap_ch_i==0 or ofmap_size_i==0; in that case start is ignored.
  - RUN → DRAIN when the last pixel's final psum is accepted.
  - DRAIN → DONE when that result handshakes (conv_valid & conv_ready).
  - DONE → RUN only on a new start.
- start_i in any state aborts the current operation. It clears the accumulator, ch/pixel counters and output register, then relatches config; this takes precedence over a same-cycle psum or output handshake.
- Psum accept = pvalid_i & pready_o. `pready_o[c] = RUN & (!conv_valid_o[c] | conv_ready_i[c])`, giving zero-bubble streaming.
- Channel count ch_cnt runs 0..ifmap_ch-1.
  - On accept: acc ← (ch_cnt==0 ? sext(psum) : acc+sext(psum)).
  - On the final channel, sum = acc+psum (or psum if ifmap_ch==1), which enters the requant path, and ch_cnt wraps to 0.
- Requant, at ACC_W+1 bits, signed:
  - t = (sum + sext(bias)) >>> shift_i (floor).
  - If relu_en and t<0, then t=0.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Output register loads result, addr = pix_cnt, and last = (pix_cnt == size²-1). pix_cnt then increments.
- Columns run independently; done_o waits for the slowest column.

## Timing
- Reset values:
  - All outputs 0 (pready_o 0, conv_valid_o 0, done_o 0, busy_o 0).
  - Columns in IDLE.
  - Config registers 0.
- Latency: the final psum accepted at edge k gives conv_valid_o high from edge k (visible in cycle k+1). Output is registered; there is no combinational path from psum_i to conv_result_o.
- conv_valid_o stays high with stable result, addr and last until the handshake.
- busy_o rises the cycle after start; done_o rises the cycle after the last column's final handshake.
- Psums offered outside RUN are never accepted (pready_o 0).
- Reset mid-operation: immediate return to reset state; no partial output.

## Test plan
- size=2, ch=3, bias=0, shift=0, psums 10,20,30 for each pixel → results 60 at addr 0,1,2,3; last only on addr 3; done_o after the 4th handshake.
- Requant: ch=2, psums 100,100, bias=0.
  - shift=2 → 50.
  - shift=0 → 127 (saturation).
  - psums -300,-300 → -128.
- ReLU/bias: ch=1, psum -40, bias 10.
  - relu_en=0 → -30.
  - relu_en=1 → 0.
- Backpressure: conv_ready_i[3]=0 for 5 cycles with pvalid held high. pready_o[3] drops after one result is pending; no psum is lost. The result stays stable, then streams in order after release. Other columns are unaffected.
- Restart: start_i asserted mid-map (pixel 2 of 9). Outputs clear, addr restarts at 0 with the new config, and no stale result appears.
- ch=1, size=1: a single psum yields one result with last=1 and addr=0. start with ifmap_ch_i=0 → stays IDLE, busy_o stays 0.
